// File: rtl/rx_sample_buffer_if.sv
// Sample-in, CPU-drain and overflow status bundle for rx_sample_buffer.
// slave is the buffer side; master is the driver side (CPU, receiver, host).
interface rx_sample_buffer_if #(
  parameter int unsigned AW = 11
) ();
  logic          in_valid;
  logic [23:0]   in_i;
  logic [23:0]   in_q;
  logic          rx_rd;
  logic [15:0]   rx_dout;
  logic          rx_rst;
  logic          hb_orst;
  logic          hb_ovfl;
  logic          rx_frame_rdy;
  logic [AW:0]   rx_count;

  modport slave (
    input  in_valid, in_i, in_q, rx_rd, rx_rst, hb_orst,
    output rx_dout, hb_ovfl, rx_frame_rdy, rx_count
  );

  modport master (
    output in_valid, in_i, in_q, rx_rd, rx_rst, hb_orst,
    input  rx_dout, hb_ovfl, rx_frame_rdy, rx_count
  );
endinterface

// File: rtl/rx_sample_buffer.sv
// Packs 24-bit I/Q samples into 16-bit words in a BRAM FIFO with a 2-entry read prefetch.
// Define RX_SEQ_EN to prefix every frame with a 16-bit frame sequence word.
module rx_sample_buffer #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned NSAMP = 170,
  parameter int unsigned AW    = 11
) (
  input  logic              hb_clk,
  input  logic              hb_rst,
  rx_sample_buffer_if.slave bus
);

`ifdef RX_SEQ_EN
  localparam int unsigned FrameWords = 3 * NSAMP + 1;
  localparam int unsigned SW         = (NSAMP > 1) ? $clog2(NSAMP) : 1;
`else
  localparam int unsigned FrameWords = 3 * NSAMP;
`endif
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);
  localparam logic [AW:0] FrameW = (AW + 1)'(FrameWords);

  typedef enum logic [1:0] {StIdle, StW0, StW1, StW2} state_e;

  state_e        state_q, state_d;
  logic [23:0]   i_q, q_q;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, fptr_q;
  logic [AW:0]   count_q, count_d, free, need, mem_cnt;
  logic [15:0]   pf0_q, pf1_q, wdata;
  logic [1:0]    pf_cnt_q, pf_after;
  logic          ovfl_q, frame_rdy_q;
  logic          wr, accept, drop, pop, fetch, flush;

`ifdef RX_SEQ_EN
  logic [SW-1:0] samp_q;
  logic [15:0]   seq_q;
  logic          frame_start;
  assign frame_start = (samp_q == '0);
`endif

  assign flush = hb_rst || bus.rx_rst;

  // rx_count covers both unfetched BRAM words and prefetched words.
  always_comb begin
    free     = DepthW - count_q;
    mem_cnt  = count_q - {{(AW - 1){1'b0}}, pf_cnt_q};
    pop      = bus.rx_rd && (pf_cnt_q != 2'd0);
    pf_after = pf_cnt_q - {1'b0, pop};
    fetch    = (mem_cnt != '0) && (pf_after != 2'd2);
  end

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    wdata   = '0;
    accept  = 1'b0;
    need    = (AW + 1)'(3);
`ifdef RX_SEQ_EN
    if (frame_start) need = (AW + 1)'(4);
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && (free >= need)) begin
          accept  = 1'b1;
          state_d = StW0;
`ifdef RX_SEQ_EN
          // SEQ word goes out in the accept cycle so the 4-cycle sample pitch still fits.
          if (frame_start) begin
            wr    = 1'b1;
            wdata = seq_q;
          end
`endif
        end
      end
      StW0: begin
        wr      = 1'b1;
        wdata   = i_q[23:8];
        state_d = StW1;
      end
      StW1: begin
        wr      = 1'b1;
        wdata   = q_q[23:8];
        state_d = StW2;
      end
      StW2: begin
        wr      = 1'b1;
        wdata   = {i_q[7:0], q_q[7:0]};
        state_d = StIdle;
      end
    endcase
    drop    = bus.in_valid && !accept;
    count_d = count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
  end

  always_ff @(posedge hb_clk) begin
    if (wr && !flush) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge hb_clk) begin
    if (flush) begin
      state_q     <= StIdle;
      i_q         <= '0;
      q_q         <= '0;
      wptr_q      <= '0;
      fptr_q      <= '0;
      count_q     <= '0;
      pf0_q       <= '0;
      pf1_q       <= '0;
      pf_cnt_q    <= '0;
      ovfl_q      <= 1'b0;
      frame_rdy_q <= 1'b0;
`ifdef RX_SEQ_EN
      samp_q      <= '0;
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_rdy_q <= (count_q >= FrameW);
      if (accept) begin
        i_q <= bus.in_i;
        q_q <= bus.in_q;
      end
      if (wr) wptr_q <= wptr_q + 1'b1;
      pf_cnt_q <= pf_after + {1'b0, fetch};
      if (pop) pf0_q <= pf1_q;
      // Registered BRAM read lands directly in the first free prefetch slot.
      if (fetch) begin
        fptr_q <= fptr_q + 1'b1;
        if (pf_after == 2'd0) pf0_q <= mem[fptr_q];
        else                  pf1_q <= mem[fptr_q];
      end
      if (drop)             ovfl_q <= 1'b1;
      else if (bus.hb_orst) ovfl_q <= 1'b0;
`ifdef RX_SEQ_EN
      // Frame timeline advances on every strobe, dropped or not.
      if (bus.in_valid) begin
        if (samp_q == SW'(NSAMP - 1)) begin
          samp_q <= '0;
          seq_q  <= seq_q + 16'd1;
        end else begin
          samp_q <= samp_q + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.rx_dout      = (pf_cnt_q != 2'd0) ? pf0_q : 16'h0000;
  assign bus.hb_ovfl      = ovfl_q;
  assign bus.rx_frame_rdy = frame_rdy_q;
  assign bus.rx_count     = count_q;

endmodule

// File: tb/tb_rx_sample_buffer.sv
// Self-checking bench for rx_sample_buffer: timestamped word-queue model compared every cycle,
// plus directed literal checks. Honours RX_SEQ_EN when defined.
module tb_rx_sample_buffer;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned NSAMP = 170;
  localparam int unsigned AW    = 11;
`ifdef RX_SEQ_EN
  localparam int FRAME_W  = 3 * NSAMP + 1;
  localparam int N_FILL   = 681;
  localparam int FULL_CNT = 2048;
  localparam bit SEQ      = 1'b1;
`else
  localparam int FRAME_W  = 3 * NSAMP;
  localparam int N_FILL   = 682;
  localparam int FULL_CNT = 2046;
  localparam bit SEQ      = 1'b0;
`endif

  logic hb_clk = 1'b0;
  logic hb_rst;
  rx_sample_buffer_if #(.AW(AW)) bus ();

  rx_sample_buffer #(.DEPTH(DEPTH), .NSAMP(NSAMP), .AW(AW)) dut (
    .hb_clk (hb_clk),
    .hb_rst (hb_rst),
    .bus    (bus)
  );

  always #5 hb_clk = ~hb_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words with the cycle they are written; counted the cycle after, poppable two after.
  logic [15:0] mw[$];
  int          mc[$];
  int          cyc = 0;
  bit          m_ovfl, m_frdy;
  int          m_busy_until, m_samp;
  logic [15:0] m_seq;

  function automatic int m_count(input int c);
    int k = mw.size();
    while (k > 0 && mc[k-1] >= c) k--;
    return k;
  endfunction

  always @(posedge hb_clk) begin
    int c, cnt, need;
    bit fs, drop;
    c = cyc;
    if (hb_rst || bus.rx_rst) begin
      mw.delete(); mc.delete();
      m_ovfl = 0; m_frdy = 0; m_busy_until = 0; m_samp = 0; m_seq = '0;
    end else begin
      cnt    = m_count(c);
      m_frdy = (cnt >= FRAME_W);
      if (bus.rx_rd && mw.size() > 0 && mc[0] <= c - 2) begin
        void'(mw.pop_front()); void'(mc.pop_front());
      end
      drop = 0;
      if (bus.in_valid) begin
        fs   = (m_samp == 0);
        need = (SEQ && fs) ? 4 : 3;
        if (c < m_busy_until || int'(DEPTH) - cnt < need) drop = 1;
        else begin
          if (SEQ && fs) begin mw.push_back(m_seq); mc.push_back(c); end
          mw.push_back(bus.in_i[23:8]);             mc.push_back(c + 1);
          mw.push_back(bus.in_q[23:8]);             mc.push_back(c + 2);
          mw.push_back({bus.in_i[7:0], bus.in_q[7:0]}); mc.push_back(c + 3);
          m_busy_until = c + 4;
        end
        if (m_samp == int'(NSAMP) - 1) begin m_samp = 0; m_seq = m_seq + 16'd1; end
        else m_samp = m_samp + 1;
      end
      if (drop) m_ovfl = 1;
      else if (bus.hb_orst) m_ovfl = 0;
    end
    cyc = cyc + 1;
  end

  always @(negedge hb_clk) begin
    logic [15:0] ed;
    if (chk_en && !hb_rst) begin
      ed = (mw.size() > 0 && mc[0] <= cyc - 2) ? mw[0] : 16'h0000;
      check("m_dout",  {16'h0, bus.rx_dout}, {16'h0, ed});
      check("m_count", 32'(bus.rx_count), 32'(m_count(cyc)));
      check("m_ovfl",  32'(bus.hb_ovfl), 32'(m_ovfl));
      check("m_frdy",  32'(bus.rx_frame_rdy), 32'(m_frdy));
    end
  end

  task automatic tick();
    @(posedge hb_clk); #1;
  endtask

  task automatic sample(input logic [23:0] i, input logic [23:0] q);
    bus.in_valid = 1'b1; bus.in_i = i; bus.in_q = q;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic rd_expect(input logic [15:0] w, input string name);
    bus.rx_rd = 1'b1;
    check(name, {16'h0, bus.rx_dout}, {16'h0, w});
    tick();
    bus.rx_rd = 1'b0;
  endtask

  task automatic flush();
    bus.rx_rst = 1'b1; tick(); bus.rx_rst = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_i = '0; bus.in_q = '0; bus.rx_rd = 0;
    bus.rx_rst = 0; bus.hb_orst = 0; hb_rst = 1'b1;
    repeat (3) tick();
    hb_rst = 1'b0; chk_en = 1'b1;
    check("rst_count", 32'(bus.rx_count), 0);
    check("rst_ovfl",  32'(bus.hb_ovfl), 0);
    check("rst_dout",  {16'h0, bus.rx_dout}, 0);
    check("rst_frdy",  32'(bus.rx_frame_rdy), 0);

    // Single sample packing and back-to-back reads
    sample(24'h123456, 24'hABCDEF);
    check("one_count", 32'(bus.rx_count), SEQ ? 4 : 3);
    tick();
`ifdef RX_SEQ_EN
    rd_expect(16'h0000, "one_seq");
`endif
    rd_expect(16'h1234, "one_w0");
    rd_expect(16'hABCD, "one_w1");
    rd_expect(16'h56EF, "one_w2");
    check("one_drained", 32'(bus.rx_count), 0);

    // Read on empty
    bus.rx_rd = 1'b1; tick(); bus.rx_rd = 1'b0;
    check("empty_dout",  {16'h0, bus.rx_dout}, 0);
    check("empty_count", 32'(bus.rx_count), 0);
    check("empty_ovfl",  32'(bus.hb_ovfl), 0);

    // Frame-ready threshold
    flush();
    for (int k = 0; k < int'(NSAMP) - 1; k++)
      sample(24'h0A0000 + 24'(k), 24'h050000 + 24'(k));
    check("frm_pre_frdy", 32'(bus.rx_frame_rdy), 0);
    sample(24'h0A00FF, 24'h0500FF);
    check("frm_count", 32'(bus.rx_count), FRAME_W);
    check("frm_lag_frdy", 32'(bus.rx_frame_rdy), 0);
    tick();
    check("frm_frdy", 32'(bus.rx_frame_rdy), 1);
    check("frm_head", {16'h0, bus.rx_dout}, SEQ ? 32'h0 : 32'h0A00);

    // Fill near full, then overflow
    flush();
    for (int k = 0; k < N_FILL; k++)
      sample(24'(k * 32'h00010203), ~24'(k * 32'h00010203));
    check("fill_count", 32'(bus.rx_count), FULL_CNT);
    sample(24'h777777, 24'h888888);
    check("ovf_flag",  32'(bus.hb_ovfl), 1);
    check("ovf_count", 32'(bus.rx_count), FULL_CNT);
    bus.hb_orst = 1'b1; tick(); bus.hb_orst = 1'b0;
    check("orst_clr", 32'(bus.hb_ovfl), 0);
    bus.hb_orst = 1'b1; bus.in_valid = 1'b1; tick();
    bus.hb_orst = 1'b0; bus.in_valid = 1'b0;
    check("set_wins", 32'(bus.hb_ovfl), 1);
    repeat (3) tick();
    bus.hb_orst = 1'b1; tick(); bus.hb_orst = 1'b0;
    check("orst_clr2", 32'(bus.hb_ovfl), 0);

    // Drain everything back-to-back, then write/read across the pointer wrap
    bus.rx_rd = 1'b1;
    repeat (FULL_CNT) tick();
    bus.rx_rd = 1'b0;
    check("drain_count", 32'(bus.rx_count), 0);
    sample(24'h112233, 24'h445566);
    sample(24'h778899, 24'hAABBCC);
    tick();
    rd_expect(16'h1122, "wrap_w0");
    rd_expect(16'h4455, "wrap_w1");
    rd_expect(16'h3366, "wrap_w2");
    rd_expect(16'h7788, "wrap_w3");
    rd_expect(16'hAABB, "wrap_w4");
    rd_expect(16'h99CC, "wrap_w5");
    check("wrap_count", 32'(bus.rx_count), 0);

    // Spacing violation: second strobe two cycles after the first
    flush();
    bus.in_valid = 1'b1; bus.in_i = 24'hDEADBE; bus.in_q = 24'h0F1E2D; tick();
    bus.in_valid = 1'b0; tick();
    bus.in_valid = 1'b1; bus.in_i = 24'h111111; bus.in_q = 24'h222222; tick();
    bus.in_valid = 1'b0; repeat (3) tick();
    check("spc_ovfl",  32'(bus.hb_ovfl), 1);
    check("spc_count", 32'(bus.rx_count), SEQ ? 4 : 3);
`ifdef RX_SEQ_EN
    rd_expect(16'h0000, "spc_seq");
`endif
    rd_expect(16'hDEAD, "spc_w0");
    rd_expect(16'h0F1E, "spc_w1");
    rd_expect(16'hBE2D, "spc_w2");

    // Flush while packing in W1 with words pending
    flush();
    sample(24'h010203, 24'h040506);
    tick();
    bus.in_valid = 1'b1; bus.in_i = 24'hABABAB; bus.in_q = 24'hCDCDCD; tick();
    bus.in_valid = 1'b0; tick();
    flush();
    check("fl_count", 32'(bus.rx_count), 0);
    check("fl_dout",  {16'h0, bus.rx_dout}, 0);
    sample(24'hFEDCBA, 24'h987654);
    check("fl_new_count", 32'(bus.rx_count), SEQ ? 4 : 3);
    tick();
`ifdef RX_SEQ_EN
    rd_expect(16'h0000, "fl_seq");
`endif
    rd_expect(16'hFEDC, "fl_w0");
    rd_expect(16'h9876, "fl_w1");
    rd_expect(16'hBA54, "fl_w2");
    check("fl_end_count", 32'(bus.rx_count), 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
